// File: rtl/blur3x3_stream.sv
// Streaming 3x3 blur (Gaussian / box / bypass, chosen per frame) over raster pixels.
// The image width is learned from the first row. Two line buffers hold the previous
// two rows. Border pixels pass through unchanged. The tail of the frame is drained
// after the frame-end pixel.
// Optional macro BLUR3X3_ROW_CHECK_EN: sticky o_err on row-length mismatches in RUN.
module blur3x3_stream #(
    parameter int DATA_W    = 8,
    parameter int IMG_W_MAX = 640
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_pixel,
    input  logic              i_row_end,
    input  logic              i_frame_end,
    input  logic [1:0]        i_mode,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_pixel,
    output logic              o_err
);
    localparam int CW = (IMG_W_MAX > 1) ? $clog2(IMG_W_MAX) : 1;
    localparam int RW = 16;
    localparam int SW = DATA_W + 4;
    localparam int PW = DATA_W + 17;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W_MAX - 1);

    typedef enum logic [1:0] {IDLE, ROW0, RUN, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       col_q, col_d, wlast_q, wlast_d, ocol_q, ocol_d, raddr;
    logic [RW-1:0]       row_q, row_d, orow_q, orow_d, last_row_q, last_row_d;
    logic [1:0]          mode_q, mode_d;
    logic                ready_q, valid_q, err_q, fwd_q, err_set;
    logic [DATA_W-1:0]   pixel_q, out_pix;
    logic                accept, emit, border;

    logic [DATA_W-1:0]   lb0_mem [IMG_W_MAX];
    logic [DATA_W-1:0]   lb1_mem [IMG_W_MAX];
    logic [DATA_W-1:0]   rd0_q, rd1_q, fwd0_q, fwd1_q, lb0_rd, lb1_rd;
    logic [DATA_W-1:0]   win_top_q [2];
    logic [DATA_W-1:0]   win_mid_q [2];
    logic [DATA_W-1:0]   win_bot_q [2];

    logic [SW-1:0]       gauss_sum, gauss_rnd, box_sum;
    logic [PW-1:0]       box_prod;

    assign accept  = i_valid && ready_q;
    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_pixel = pixel_q;
    assign o_err   = err_q;

    // A write to the address being read in the same cycle is forwarded, so the
    // line-buffer view is always the value after the most recent write.
    assign lb0_rd = fwd_q ? fwd0_q : rd0_q;
    assign lb1_rd = fwd_q ? fwd1_q : rd1_q;

    // Next-state logic: input position counters, learned width, output position, drain.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        wlast_d    = wlast_q;
        mode_d     = mode_q;
        last_row_d = last_row_q;
        ocol_d     = ocol_q;
        orow_d     = orow_q;
        emit       = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                mode_d     = i_mode;
                orow_d     = '0;
                ocol_d     = '0;
                last_row_d = '0;
                if (i_row_end || COL_MAX == '0) begin
                    col_d   = '0;
                    row_d   = RW'(1);
                    wlast_d = '0;
                end else begin
                    col_d = CW'(1);
                    row_d = '0;
                end
                state_d = i_frame_end ? DRAIN : ROW0;
            end
            ROW0: if (accept) begin
                last_row_d = row_q;
                if (i_row_end || col_q == COL_MAX) begin
                    wlast_d = col_q;
                    col_d   = '0;
                    row_d   = row_q + RW'(1);
                    state_d = RUN;
                end else begin
                    col_d = col_q + CW'(1);
                end
                if (i_frame_end) state_d = DRAIN;
            end
            RUN: if (accept) begin
                last_row_d = row_q;
                // Only the first pixel of row 1 has no output W+1 pixels behind it.
                emit = !(row_q == RW'(1) && col_q == '0);
                if (col_q == wlast_q) begin
                    col_d = '0;
                    row_d = row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
                if (i_frame_end) state_d = DRAIN;
            end
            default: emit = 1'b1;
        endcase
        if (emit) begin
            if (ocol_q == wlast_q) begin
                ocol_d = '0;
                orow_d = orow_q + RW'(1);
            end else begin
                ocol_d = ocol_q + CW'(1);
            end
        end
        if (state_q == DRAIN && orow_d == row_q && ocol_d == col_q) state_d = IDLE;
        // While draining, the read port prefetches the centre of the next output.
        raddr = (state_d == DRAIN) ? ocol_d : col_d;
    end

`ifdef BLUR3X3_ROW_CHECK_EN
    assign err_set = (state_q == RUN) && accept &&
                     ((i_row_end && col_q != wlast_q) || (!i_row_end && col_q == wlast_q));
`else
    assign err_set = 1'b0;
`endif

    // Window sums: two stored columns plus the column arriving with this accept.
    always_comb begin
        gauss_sum = SW'(win_top_q[0]) + (SW'(win_mid_q[0]) << 1) + SW'(win_bot_q[0])
                  + (SW'(win_top_q[1]) << 1) + (SW'(win_mid_q[1]) << 2) + (SW'(win_bot_q[1]) << 1)
                  + SW'(lb1_rd) + (SW'(lb0_rd) << 1) + SW'(i_pixel);
        box_sum   = SW'(win_top_q[0]) + SW'(win_mid_q[0]) + SW'(win_bot_q[0])
                  + SW'(win_top_q[1]) + SW'(win_mid_q[1]) + SW'(win_bot_q[1])
                  + SW'(lb1_rd) + SW'(lb0_rd) + SW'(i_pixel);
        gauss_rnd = gauss_sum + SW'(8);
        box_prod  = PW'(box_sum) * PW'(7282) + PW'(32768);
        border    = (orow_q == '0) || (ocol_q == '0) || (ocol_q == wlast_q);
        if (state_q == DRAIN) begin
            out_pix = (orow_q == last_row_q) ? lb0_rd : lb1_rd;
        end else if (border || mode_q == 2'd0 || mode_q == 2'd3) begin
            out_pix = win_mid_q[1];
        end else if (mode_q == 2'd1) begin
            out_pix = gauss_rnd[SW-1:4];
        end else begin
            out_pix = box_prod[DATA_W+15:16];
        end
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            wlast_q    <= '0;
            mode_q     <= '0;
            last_row_q <= '0;
            ocol_q     <= '0;
            orow_q     <= '0;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            pixel_q    <= '0;
            err_q      <= 1'b0;
            fwd_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            wlast_q    <= wlast_d;
            mode_q     <= mode_d;
            last_row_q <= last_row_d;
            ocol_q     <= ocol_d;
            orow_q     <= orow_d;
            ready_q    <= (state_d != DRAIN);
            valid_q    <= emit;
            if (emit) pixel_q <= out_pix;
            err_q      <= err_q | err_set;
            fwd_q      <= accept && (raddr == col_q);
        end
    end

    // Line buffers: written at the input column, registered read at the prefetch address.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            lb0_mem[col_q] <= i_pixel;
            lb1_mem[col_q] <= lb0_rd;
        end
        rd0_q <= lb0_mem[raddr];
        rd1_q <= lb1_mem[raddr];
    end

    // Window shift and forwarding capture on every accepted pixel.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            win_top_q[0] <= win_top_q[1];
            win_mid_q[0] <= win_mid_q[1];
            win_bot_q[0] <= win_bot_q[1];
            win_top_q[1] <= lb1_rd;
            win_mid_q[1] <= lb0_rd;
            win_bot_q[1] <= i_pixel;
            fwd0_q       <= i_pixel;
            fwd1_q       <= lb0_rd;
        end
    end
endmodule
